bcd4221_to_8421_decoder: RTL and testbench
==========================================

// Module: bcd4221_to_8421_decoder
// PURPOSE
// Converts a multi-digit BCD-4221 word (the multiplier's internal operand and
// partial-product digit code) back to BCD-8421 for the result/output path.
// Digit-serial: one digit per clock, LSD first, behind valid/ready handshakes.
// Also flags a nonzero top digit (result exceeds the 16-bit/4-digit operand range).
// PARAMETERS
// NDIG  5  number of BCD digits per word (>=2); word width = 4*NDIG bits
// PORTS
// clk        in   1        rising-edge clock
// rst_n      in   1        asynchronous active-low reset
// in_valid   in   1        X_4221 holds a word to convert
// in_ready   out  1        decoder can accept a word
// X_4221     in   4*NDIG   input word, digit i at bits [4i+3:4i], 4221 weights
// out_valid  out  1        Y_8421/ovf hold a completed result
// out_ready  in   1        consumer accepts the result
// Y_8421     out  4*NDIG   decoded word, digit i at bits [4i+3:4i], 8421 weights
// ovf        out  1        top digit of Y_8421 nonzero
// busy       out  1        state != IDLE
// BEHAVIOUR
// - Digit map: value = 4*b3 + 2*b2 + 2*b1 + b0; all 16 codes legal, range 0..9;
//   redundant codes map to the same value (0110 and 1000 -> 4; 0111 and 1001 -> 5).
// - FSM states are IDLE, CONV and DONE.
// - IDLE: in_ready=1. When in_valid&in_ready is sampled at edge k:
//   - latch X_4221 into the shadow register;
//   - clear the digit counter to 0;
//   - go to CONV.
// - CONV: in_ready=0.
//   - At each edge, decode shadow digit[cnt] into result digit[cnt] and cnt++.
//   - At the edge where cnt==NDIG-1: update ovf from the top-digit result, go to DONE.
//   - Edges k+1..k+NDIG therefore decode digits 0..NDIG-1.
// - DONE: out_valid=1; Y_8421 and ovf are stable while out_valid=1.
//   - Edge with out_ready=1: go to IDLE. No new word is accepted in that same cycle.
// - Latency: out_valid rises after edge k+NDIG.
// - Minimum period between accepted words: NDIG+2 cycles (accept, NDIG CONV, DONE).
// - X_4221 and in_valid are ignored outside IDLE; the shadow register is not disturbed.
// - out_ready is ignored unless out_valid=1.
// - After the output handshake, Y_8421/ovf keep their last values (they are not cleared).
// - Reset (async, any state, mid-conversion included):
//   - state goes to IDLE and cnt to 0;
//   - shadow register, Y_8421 and ovf are cleared to 0;
//   - out_valid=0, busy=0;
//   - in_ready=1 once rst_n is released;
//   - the partial conversion is discarded with no output.
// - Every digit of Y_8421 is always legal 8421 BCD (0..9).
// TESTING
// 1. Reset: hold rst_n=0 -> in_ready=1, out_valid=0, busy=0, Y_8421=0, ovf=0.
// 2. Basic: X_4221=20'h0FE71, in_valid=1 -> in_ready=0 for 6 cycles, out_valid rises
//    5 cycles after accept, Y_8421=20'h09851, ovf=0.
// 3. Redundant codes: X_4221=20'h07986 -> Y_8421=20'h05544, ovf=0; then
//    X_4221=20'h86000 -> Y_8421=20'h44000, ovf=1.
// 4. Backpressure: out_ready=0 for 10 cycles in DONE, then 1 -> out_valid and Y_8421 held
//    stable throughout; X_4221 changes ignored; in_ready returns 1 one cycle after release.
// 5. Mid-op reset: assert rst_n=0 on the 3rd CONV cycle -> outputs return to reset values
//    immediately; a new word 20'h00001 then yields Y_8421=20'h00001.
// 6. Exhaustive: all 16 codes in each digit position (randomised words, random
//    out_ready) -> Y_8421 matches the weight-sum model.

Source files
------------

// File: rtl/bcd4221_to_8421_decoder.sv
// Digit-serial BCD-4221 to BCD-8421 word decoder with valid/ready handshakes.
// Converts one digit per clock, least significant digit first; flags a nonzero top digit.
module bcd4221_to_8421_decoder #(
    parameter int NDIG = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] X_4221,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] Y_8421,
    output logic              ovf,
    output logic              busy
);

    localparam int CW = $clog2(NDIG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [4*NDIG-1:0] shadow_reg;
    logic [4*NDIG-1:0] y_reg;
    logic              ovf_reg;
    logic [3:0]        dec_digit [NDIG];
    logic              accept;
    logic              last_digit;

    // Weight sum 4*b3 + 2*b2 + 2*b1 + b0 never exceeds 9, so the result is valid 8421.
    function automatic logic [3:0] decode_4221(input logic [3:0] code);
        logic [3:0] value;
        value = {1'b0, code[3], 2'b00}
              + {2'b00, code[2], 1'b0}
              + {2'b00, code[1], 1'b0}
              + {3'b000, code[0]};
        return value;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_dec
            assign dec_digit[gi] = decode_4221(shadow_reg[4*gi +: 4]);
        end
    endgenerate

    assign accept     = (state_reg == IDLE) && in_valid;
    assign last_digit = (state_reg == CONV) && (cnt_reg == CW'(NDIG - 1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CONV;
                    cnt_next   = '0;
                end
            end
            CONV: begin
                if (last_digit) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Shadow only loads in IDLE, so input changes during CONV/DONE cannot corrupt a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= '0;
        end else if (accept) begin
            shadow_reg <= X_4221;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg   <= '0;
            ovf_reg <= 1'b0;
        end else if (state_reg == CONV) begin
            for (int i = 0; i < NDIG; i++) begin
                if (cnt_reg == CW'(i)) begin
                    y_reg[4*i +: 4] <= dec_digit[i];
                end
            end
            if (last_digit) begin
                ovf_reg <= (dec_digit[NDIG-1] != 4'd0);
            end
        end
    end

    assign Y_8421 = y_reg;
    assign ovf    = ovf_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_bcd4221_to_8421_decoder.sv
// Scoreboard bench for the BCD-4221 to 8421 decoder: accepted words push a model
// result, a monitor pops and compares on each output handshake.
module tb_bcd4221_to_8421_decoder;

    localparam int NDIG = 5;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X_4221;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Y_8421;
    logic         ovf;
    logic         busy;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         o;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   rand_ready = 1'b0;

    bcd4221_to_8421_decoder #(.NDIG(NDIG)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .X_4221   (X_4221),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Y_8421   (Y_8421),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference: sum the digit values as a decimal number, then re-split it into decimal digits.
    function automatic void model(input logic [W-1:0] x, output logic [W-1:0] y, output logic o);
        longint total = 0;
        longint p     = 1;
        longint top;
        logic [3:0] c;
        for (int d = 0; d < NDIG; d++) begin
            c = x[4*d +: 4];
            total += (4 * int'(c[3]) + 2 * int'(c[2]) + 2 * int'(c[1]) + int'(c[0])) * p;
            p *= 10;
        end
        p = 1;
        for (int d = 0; d < NDIG; d++) begin
            y[4*d +: 4] = 4'((total / p) % 10);
            p *= 10;
        end
        top = p / 10;
        o = (total >= top);
    endfunction

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    task automatic recorder();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && in_valid && in_ready) begin
                e.x = X_4221;
                model(e.x, e.y, e.o);
                sb.push_back(e);
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic legal;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", W'(1), W'(0));
                end else begin
                    e = sb.pop_front();
                    check("y_8421", Y_8421, e.y);
                    check("ovf", W'(ovf), W'(e.o));
                    legal = 1'b1;
                    for (int d = 0; d < NDIG; d++) begin
                        if (Y_8421[4*d +: 4] > 4'd9) legal = 1'b0;
                    end
                    check("digit_legal", W'(legal), W'(1));
                    $display("[TB] x=%h y=%h ovf=%0d exp_y=%h exp_ovf=%0d", e.x, Y_8421, ovf, e.y, e.o);
                end
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send_word(input logic [W-1:0] x);
        int n = 0;
        in_valid = 1'b1;
        X_4221   = x;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check("accept_timeout", W'(0), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        X_4221   = W'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(in_ready && sb.size() == 0) && n < 500);
        if (!(in_ready && sb.size() == 0)) check("drain_timeout", W'(sb.size()), W'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int low, first_ov, n;
        logic [W-1:0] x, ey;
        logic eo;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; X_4221 = '0;
        fork
            recorder();
            monitor();
            ready_driver();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_y", Y_8421, W'(0));
        check("rst_ovf", W'(ovf), W'(0));
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic word with latency and in_ready timing
        out_ready = 1'b1;
        send_word(20'h0FE71);
        low = 0; first_ov = 0; n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (out_valid && first_ov == 0) first_ov = n;
            if (in_ready) break;
            low++;
        end
        check("in_ready_low_cycles", W'(low), W'(NDIG + 1));
        check("latency_edges", W'(first_ov - 1), W'(NDIG));
        @(posedge clk); #1;

        // Redundant codes and overflow
        send_word(20'h07986);
        wait_drain();
        send_word(20'h86000);
        wait_drain();

        // Backpressure: output held for 10 cycles while inputs wiggle
        out_ready = 1'b0;
        x = 20'h3A5C2;
        model(x, ey, eo);
        send_word(x);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", W'(out_valid), W'(1));
            check("bp_y_hold", Y_8421, ey);
            check("bp_ovf_hold", W'(ovf), W'(eo));
            @(posedge clk); #1;
            X_4221   = W'($urandom);
            in_valid = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("bp_in_ready_before_release", W'(in_ready), W'(0));
        @(negedge clk);
        check("bp_in_ready_after_release", W'(in_ready), W'(1));
        check("bp_out_valid_dropped", W'(out_valid), W'(0));
        @(posedge clk); #1;

        // Reset on the third CONV cycle discards the word
        send_word(20'h99999);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_in_ready", W'(in_ready), W'(1));
        check("mid_rst_out_valid", W'(out_valid), W'(0));
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_y", Y_8421, W'(0));
        check("mid_rst_ovf", W'(ovf), W'(0));
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(20'h00001);
        wait_drain();

        // Randomised words; the first 16 sweep every code through every digit position
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i < 16) begin
                for (int d = 0; d < NDIG; d++) x[4*d +: 4] = 4'((i + 3 * d) % 16);
            end else begin
                x = W'($urandom);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_word(x);
        end
        wait_drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        check("scoreboard_empty", W'(sb.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
